// File: rtl/sl_ahb_to_sram.sv
// AHB-Lite zero-wait-state slave feeding a single-port SRAM through a one-entry posted write buffer.
// Define SL_AHB_SRAM_ERR_EN to give misaligned/oversized transfers a two-cycle ERROR response.
module sl_ahb_to_sram #(
    parameter int AW = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWREN,
    output logic          SRAMCS,
    input  logic [31:0]   SRAMRDATA
);

    logic          acc_raw, acc, rd_acc, wr_acc, drain, load, hit;
    logic [3:0]    mask;

    logic          ph_valid_q, ph_valid_d;
    logic [AW-3:0] ph_addr_q, ph_addr_d;
    logic [3:0]    ph_mask_q, ph_mask_d;
    logic          rd_dphase_q, rd_dphase_d;
    logic [AW-3:0] rd_addr_q, rd_addr_d;
    logic          buf_valid_q, buf_valid_d;
    logic [AW-3:0] buf_addr_q, buf_addr_d;
    logic [3:0]    buf_mask_q, buf_mask_d;
    logic [31:0]   buf_data_q, buf_data_d;

    logic unused_htrans;
    assign unused_htrans = HTRANS[0];

    assign acc_raw = HSEL & HREADY & HTRANS[1] & ~RESET;

`ifdef SL_AHB_SRAM_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   bad, err_acc;

    assign bad     = ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00)) |
                     (HSIZE > 3'd2);
    assign err_acc = acc_raw & bad & (state_q != ST_ERR1);
    assign acc     = acc_raw & ~bad & (state_q != ST_ERR1);

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_IDLE: if (err_acc) state_d = ST_ERR1;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                state_d = err_acc ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (RESET) begin
            HREADYOUT = 1'b1;
            HRESP     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end
`else
    assign acc       = acc_raw;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

    assign rd_acc = acc & ~HWRITE;
    assign wr_acc = acc & HWRITE;

    // Misaligned low bits fold onto the naturally aligned lanes; sizes above word act as word.
    always_comb begin
        case (HSIZE)
            3'd0:    mask = 4'b0001 << HADDR[1:0];
            3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign drain = buf_valid_q & ~rd_acc & ~RESET;
    assign load  = ph_valid_q & HREADY & ~RESET;

    assign SRAMCS    = rd_acc | drain;
    assign SRAMADDR  = rd_acc ? HADDR[AW-1:2] : buf_addr_q;
    assign SRAMWDATA = buf_data_q;
    assign SRAMWREN  = drain ? buf_mask_q : 4'b0000;

    // The buffer only drains on non-read cycles, so a still-valid entry may be newer than SRAM.
    assign hit = buf_valid_q & (buf_addr_q == rd_addr_q);

    always_comb begin
        HRDATA = 32'h0;
        if (rd_dphase_q & ~RESET) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = (hit & buf_mask_q[i]) ? buf_data_q[8*i +: 8]
                                                         : SRAMRDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        ph_valid_d  = ph_valid_q;
        ph_addr_d   = ph_addr_q;
        ph_mask_d   = ph_mask_q;
        rd_dphase_d = rd_dphase_q;
        rd_addr_d   = rd_addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_mask_d  = buf_mask_q;
        buf_data_d  = buf_data_q;

        if (HREADY) begin
            ph_valid_d  = wr_acc;
            rd_dphase_d = rd_acc;
        end
        if (wr_acc) begin
            ph_addr_d = HADDR[AW-1:2];
            ph_mask_d = mask;
        end
        if (rd_acc) rd_addr_d = HADDR[AW-1:2];

        if (drain) buf_valid_d = 1'b0;
        if (load) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = ph_addr_q;
            buf_mask_d  = ph_mask_q;
            buf_data_d  = HWDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ph_valid_q  <= 1'b0;
            ph_addr_q   <= '0;
            ph_mask_q   <= 4'b0000;
            rd_dphase_q <= 1'b0;
            rd_addr_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_mask_q  <= 4'b0000;
            buf_data_q  <= 32'h0;
        end else begin
            ph_valid_q  <= ph_valid_d;
            ph_addr_q   <= ph_addr_d;
            ph_mask_q   <= ph_mask_d;
            rd_dphase_q <= rd_dphase_d;
            rd_addr_q   <= rd_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_mask_q  <= buf_mask_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_sl_ahb_to_sram.sv
// Directed bench for sl_ahb_to_sram with a behavioural single-port SRAM attached.
module tb_sl_ahb_to_sram;
    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          hready_drv;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-3:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [3:0]    SRAMWREN;
    logic          SRAMCS;
    logic [31:0]   SRAMRDATA;

    int n_checks = 0;
    int n_errors = 0;

    assign HREADY = hready_drv & HREADYOUT;

    always #5 CLK = ~CLK;

    sl_ahb_to_sram #(.AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWREN(SRAMWREN),
        .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
    );

    logic [31:0]   mem [0:(1<<(AW-2))-1];
    logic          pre_we;
    logic [AW-3:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge CLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (SRAMCS) begin
            if (SRAMWREN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
            else for (int b = 0; b < 4; b++)
                if (SRAMWREN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic chk_sram(input string tag, input logic cs, input logic [3:0] wren, input logic [31:0] addr);
        check_val({tag, "_cs"}, {31'h0, SRAMCS}, {31'h0, cs});
        check_val({tag, "_wren"}, {28'h0, SRAMWREN}, {28'h0, wren});
        if (cs) check_val({tag, "_addr"}, {18'h0, SRAMADDR}, addr);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = sz;
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
    endtask

    task automatic preload(input logic [AW-3:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; hready_drv = 1'b1; HWDATA = 32'h0; HADDR = '0; HSIZE = 3'd0;
        pre_we = 1'b0; pre_addr = '0; pre_data = 32'h0;
        bus_idle();
        tick();
        preload(14'h0008, 32'h11223344);
        preload(14'h0014, 32'h99887766);
        preload(14'h001C, 32'h77777777);
        preload(14'h0000, 32'hA5A50001);

        // reset holds outputs quiet even with a read presented
        bus_rd(16'h0010, 3'd2); settle();
        chk_sram("rst", 1'b0, 4'h0, 32'h0);
        check_val("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check_val("rst_hresp", {31'h0, HRESP}, 32'h0);
        check_val("rst_hrdata", HRDATA, 32'h0);
        tick();
        RESET = 1'b0; bus_idle(); tick();
        check_val("idle_hrdata", HRDATA, 32'h0);

        // word write then idle: drain on third cycle
        bus_wr(16'h0010, 3'd2); settle(); chk_sram("w1_a", 1'b0, 4'h0, 32'h0); tick();
        bus_idle(); HWDATA = 32'hDEADBEEF; settle(); chk_sram("w1_d", 1'b0, 4'h0, 32'h0); tick();
        settle(); chk_sram("w1_drain", 1'b1, 4'hF, 32'h4);
        check_val("w1_wdata", SRAMWDATA, 32'hDEADBEEF); tick();
        bus_rd(16'h0010, 3'd2); settle(); chk_sram("r1_a", 1'b1, 4'h0, 32'h4); tick();
        bus_idle(); settle(); check_val("r1_data", HRDATA, 32'hDEADBEEF); tick();

        // byte write merged into immediate read of same word
        bus_wr(16'h0021, 3'd0); tick();
        bus_rd(16'h0020, 3'd2); HWDATA = 32'hFFFFAAFF; settle();
        chk_sram("raw_a", 1'b1, 4'h0, 32'h8); tick();
        bus_idle(); settle();
        check_val("raw_merge", HRDATA, 32'h1122AA44);
        check_val("raw_ready", {31'h0, HREADYOUT}, 32'h1);
        chk_sram("raw_drain", 1'b1, 4'h2, 32'h8); tick();
        bus_rd(16'h0020, 3'd2); tick();
        bus_idle(); settle(); check_val("raw_sram", HRDATA, 32'h1122AA44); tick();

        // back-to-back writes
        bus_wr(16'h0040, 3'd2); tick();
        bus_wr(16'h0044, 3'd2); HWDATA = 32'h01020304; settle(); chk_sram("b2b_0", 1'b0, 4'h0, 32'h0); tick();
        bus_wr(16'h0048, 3'd2); HWDATA = 32'h0A0B0C0D; settle(); chk_sram("b2b_1", 1'b1, 4'hF, 32'h10);
        check_val("b2b_1_wd", SRAMWDATA, 32'h01020304); tick();
        bus_idle(); HWDATA = 32'h5A5A0F0F; settle(); chk_sram("b2b_2", 1'b1, 4'hF, 32'h11);
        check_val("b2b_2_wd", SRAMWDATA, 32'h0A0B0C0D); tick();
        settle(); chk_sram("b2b_3", 1'b1, 4'hF, 32'h12);
        check_val("b2b_3_wd", SRAMWDATA, 32'h5A5A0F0F); tick();
        settle(); chk_sram("b2b_empty", 1'b0, 4'h0, 32'h0); tick();
        bus_rd(16'h0040, 3'd2); tick();
        bus_rd(16'h0044, 3'd2); settle(); check_val("b2b_rd0", HRDATA, 32'h01020304); tick();
        bus_rd(16'h0048, 3'd2); settle(); check_val("b2b_rd1", HRDATA, 32'h0A0B0C0D); tick();
        bus_idle(); settle(); check_val("b2b_rd2", HRDATA, 32'h5A5A0F0F); tick();

        // reads hold the buffer; first idle drains it
        bus_wr(16'h0052, 3'd1); tick();
        bus_rd(16'h0050, 3'd2); HWDATA = 32'h55661234; settle(); chk_sram("hold_0", 1'b1, 4'h0, 32'h14); tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_sram("hold_rd", 1'b1, 4'h0, 32'h14);
            check_val("hold_merge", HRDATA, 32'h55667766);
            tick();
        end
        bus_idle(); settle();
        check_val("hold_last", HRDATA, 32'h55667766);
        chk_sram("hold_drain", 1'b1, 4'hC, 32'h14);
        check_val("hold_wd", SRAMWDATA, 32'h55661234); tick();
        settle(); chk_sram("hold_empty", 1'b0, 4'h0, 32'h0); tick();
        bus_rd(16'h0050, 3'd2); tick();
        bus_idle(); settle(); check_val("hold_sram", HRDATA, 32'h55667766); tick();

        // stalled data phase captures nothing until HREADY returns
        bus_wr(16'h0060, 3'd2); tick();
        bus_idle(); hready_drv = 1'b0; HWDATA = 32'hBAD0BAD0; tick();
        hready_drv = 1'b1; HWDATA = 32'hCAFEF00D; settle(); chk_sram("stall_nocap", 1'b0, 4'h0, 32'h0); tick();
        settle(); chk_sram("stall_drain", 1'b1, 4'hF, 32'h18);
        check_val("stall_wd", SRAMWDATA, 32'hCAFEF00D); tick();

        // reset in write data phase discards the write
        bus_wr(16'h0070, 3'd2); tick();
        bus_idle(); RESET = 1'b1; HWDATA = 32'h12345678; settle(); chk_sram("rstw_0", 1'b0, 4'h0, 32'h0); tick();
        RESET = 1'b0; settle();
        chk_sram("rstw_1", 1'b0, 4'h0, 32'h0);
        check_val("rstw_hrdata", HRDATA, 32'h0);
        check_val("rstw_ready", {31'h0, HREADYOUT}, 32'h1); tick();
        settle(); chk_sram("rstw_2", 1'b0, 4'h0, 32'h0); tick();
        bus_rd(16'h0070, 3'd2); tick();
        bus_idle(); settle(); check_val("rstw_mem", HRDATA, 32'h77777777); tick();

        // misaligned word read
        bus_rd(16'h0002, 3'd2); settle();
`ifdef SL_AHB_SRAM_ERR_EN
        chk_sram("mis_a", 1'b0, 4'h0, 32'h0);
        check_val("mis_a_resp", {31'h0, HRESP}, 32'h0); tick();
        bus_idle(); settle();
        check_val("mis_e1_ready", {31'h0, HREADYOUT}, 32'h0);
        check_val("mis_e1_resp", {31'h0, HRESP}, 32'h1);
        chk_sram("mis_e1", 1'b0, 4'h0, 32'h0); tick();
        settle();
        check_val("mis_e2_ready", {31'h0, HREADYOUT}, 32'h1);
        check_val("mis_e2_resp", {31'h0, HRESP}, 32'h1); tick();
        settle(); check_val("mis_done_resp", {31'h0, HRESP}, 32'h0); tick();
`else
        chk_sram("mis_a", 1'b1, 4'h0, 32'h0); tick();
        bus_idle(); settle();
        check_val("mis_data", HRDATA, 32'hA5A50001);
        check_val("mis_resp", {31'h0, HRESP}, 32'h0); tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
